adder_64bit: RTL and testbench
==============================

// Module: adder_64bit
// PURPOSE
//   Registered 64-bit two's-complement adder with signed-overflow detection.
//   Serves as the ADD datapath slice of the Y86 ALU: adds operands a and b
//   and captures sum, carry-out and overflow in one pipeline register stage.
//   Internal adder is a structural ripple-carry chain of 64 one-bit full adders.
// PARAMETERS
//   WIDTH  64  operand/result width; only 64 is supported and verified
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous reset, active-high
//   in_valid   in   1   a/b valid this cycle; sampled on clk rise
//   a          in   64  signed operand A
//   b          in   64  signed operand B
//   sum        out  64  registered signed a+b, modulo 2^64
//   carry_out  out  1   registered unsigned carry out of bit 63
//   overflow   out  1   registered signed overflow flag
//   out_valid  out  1   sum/carry_out/overflow hold a new result
//   zf         out  1   zero flag (ADD64_FLAGS_EN only, else 0)
//   sf         out  1   sign flag (ADD64_FLAGS_EN only, else 0)
// BEHAVIOUR
//   - Reset: rst=1 forces sum=0, carry_out=0, overflow=0, out_valid=0,
//     zf=0, sf=0 at once, with no clock; held while rst=1.
//   - Combinational core: c[0]=0; s[i]=a[i]^b[i]^c[i];
//     c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]), for i=0..63.
//   - carry_out = c[64]; overflow = c[64]^c[63], which equals
//     (a[63]==b[63]) && (s[63]!=a[63]).
//   - Latency 1: when in_valid=1 at a clk rise, sum/carry_out/overflow
//     (and flags) load the result and out_valid=1 on the next cycle.
//   - When in_valid=0 at a clk rise, result registers hold their values
//     and out_valid drops to 0. No back-pressure; a new operand pair is
//     accepted every cycle.
//   - Wrap-around: sum is always the low 64 bits. Overflow does not
//     saturate or trap; the flag only reports it.
//   - Reset asserted mid-operation discards the in-flight result. The
//     first in_valid after rst falls gives out_valid one cycle later.
//   - Operands are treated identically whether signed or unsigned;
//     only the meaning of the flags differs.
// CONFIGURATION
//   ADD64_FLAGS_EN defined: zf = (s==0) and sf = s[63], registered in the
//     same cycle as sum and with the same in_valid/reset rules (Y86 ZF/SF).
//   ADD64_FLAGS_EN undefined: zf and sf are tied to constant 0 and no
//     flag logic is built. Ports stay present in both builds.
// TESTING
//   1. a=39, b=9033830, in_valid=1 -> next cycle sum=9033869, carry_out=0,
//      overflow=0, out_valid=1.
//   2. a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> sum=64'h8000_0000_0000_0000,
//      overflow=1, carry_out=0, sf=1 (flags build).
//   3. a=64'h8000_0000_0000_0000, b=-1 -> sum=64'h7FFF_FFFF_FFFF_FFFF,
//      overflow=1, carry_out=1.
//   4. a=-1, b=1 -> sum=0, carry_out=1, overflow=0, zf=1 (flags build).
//   5. Back-to-back in_valid with 3 pairs, then in_valid=0 -> three
//      results on consecutive cycles, then out_valid=0 and sum holds
//      the last result.
//   6. Assert rst between clk edges while out_valid=1 -> all outputs 0
//      immediately, before the next clk rise; recovery per scenario 1.

Source files
------------

// File: rtl/adder_64bit.sv
// Registered 64-bit ripple-carry adder with carry-out, signed overflow and
// optional Y86 ZF/SF flags (enabled by defining ADD64_FLAGS_EN).
module adder_64bit_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;
  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

// Handshake: valid-only, no ready. An operand pair with in_valid=1 at a clk
// rise is always accepted; its result appears with out_valid=1 one cycle later.
module adder_64bit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid,
  output logic             zf,
  output logic             sf
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    adder_64bit_fa u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (c[i]),
      .s_o (s[i]),
      .c_o (c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  // Result registers hold when no new operands arrive; only out_valid drops.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = s;
      carry_d = c[WIDTH];
      ovf_d   = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

`ifdef ADD64_FLAGS_EN
  logic zf_q, zf_d;
  logic sf_q, sf_d;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    if (in_valid) begin
      zf_d = (s == '0);
      sf_d = s[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
`endif
endmodule

// File: tb/tb_adder_64bit.sv
// Directed and random bench for adder_64bit: expected results are queued at
// drive time and compared as each cycle's output appears.
module tb_adder_64bit;
  localparam int W = 69;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        out_valid;
  logic        zf;
  logic        sf;

  int tests_run = 0;
  int tests_failed = 0;

  // Record layout: {out_valid, sum[63:0], carry_out, overflow, zf, sf}
  logic [W-1:0] exp_q[$];
  logic [W-2:0] last_result;

  adder_64bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .out_valid (out_valid),
    .zf        (zf),
    .sf        (sf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-2:0] model(input logic [63:0] op_a, input logic [63:0] op_b);
    logic [64:0] t;
    logic [63:0] s;
    logic        co, ov, z, f;
    t  = {1'b0, op_a} + {1'b0, op_b};
    s  = t[63:0];
    co = t[64];
    ov = (op_a[63] == op_b[63]) && (s[63] != op_a[63]);
`ifdef ADD64_FLAGS_EN
    z = (s == 64'd0);
    f = s[63];
`else
    z = 1'b0;
    f = 1'b0;
`endif
    return {s, co, ov, z, f};
  endfunction

  // Driver tasks: one queue entry per driven cycle
  task automatic drive(input logic [63:0] op_a, input logic [63:0] op_b);
    @(negedge clk);
    in_valid = 1'b1;
    a = op_a;
    b = op_b;
    last_result = model(op_a, op_b);
    exp_q.push_back({1'b1, last_result});
  endtask

  task automatic drive_idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp_q.push_back({1'b0, last_result});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"}, sum, 64'd0);
    check({tag, "_carry"}, {63'd0, carry_out}, 64'd0);
    check({tag, "_ovf"}, {63'd0, overflow}, 64'd0);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_zf"}, {63'd0, zf}, 64'd0);
    check({tag, "_sf"}, {63'd0, sf}, 64'd0);
  endtask

  // Scoreboard: pop and compare one record per clock while out of reset
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_valid", {63'd0, out_valid}, {63'd0, e[68]});
      check("sum",       sum,                e[67:4]);
      check("carry_out", {63'd0, carry_out}, {63'd0, e[3]});
      check("overflow",  {63'd0, overflow},  {63'd0, e[2]});
      check("zf",        {63'd0, zf},        {63'd0, e[1]});
      check("sf",        {63'd0, sf},        {63'd0, e[0]});
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = 64'd0;
    b = 64'd0;
    last_result = '0;
    #1;
    check_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed operand cases
    drive(64'd39, 64'd9033830);
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    drive(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    drive(64'd0, 64'd0);
    drive_idle();
    drive_idle();

    // Back-to-back pairs then idle: sum must hold the last result
    drive(64'd100, 64'd200);
    drive(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    drive(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
    drive_idle();
    drive_idle();

    // Random operands with occasional gaps
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) drive_idle();
      else drive({$urandom, $urandom}, {$urandom, $urandom});
    end

    // Asynchronous reset between edges while a result is valid
    drive(64'd5, 64'd7);
    @(posedge clk);
    #3;
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    last_result = '0;

    // Recovery
    drive(64'd39, 64'd9033830);
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    tests_failed++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end
endmodule
